// File: rtl/ped_request.sv
// ped_request -- pedestrian-side request unit.
//
// Synchronises and debounces a raw push-button, latches a crossing request
// and holds `button` high until the traffic controller answers with
// `green_p`. After each crossing a fixed cooldown is enforced; a press
// during cooldown is remembered (shown on the WAIT lamp) and re-issued as
// a request once the cooldown ends. Served crossings are counted with a
// saturating counter.
//
// Ports:
//   clk          in   system clock, rising edge
//   rst          in   synchronous active-high reset
//   btn_raw      in   asynchronous, bouncy push-button
//   green_p      in   pedestrian green from the traffic controller
//   button       out  registered request level to the controller
//   wait_lamp    out  registered WAIT indicator (request outstanding)
//   served_count out  completed crossings, saturating at all-ones
module ped_request #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int COOLDOWN_CYCLES = 8,
    parameter int CNT_W           = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             btn_raw,
    input  logic             green_p,
    output logic             button,
    output logic             wait_lamp,
    output logic [CNT_W-1:0] served_count
);

    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int CD_W = $clog2(COOLDOWN_CYCLES + 1);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CD_W-1:0] CD_LOAD = CD_W'(COOLDOWN_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REQUEST  = 2'd1,
        SERVING  = 2'd2,
        COOLDOWN = 2'd3
    } state_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    logic [SYNC_STAGES-1:0] sync_p0;
    logic                   btn_sync;
    logic [DB_W-1:0]        db_cnt_p1;
    logic                   btn_clean_p1;
    logic                   btn_clean_p2;
    logic                   press;

    state_t                 state, state_n;
    logic [CD_W-1:0]        cd_cnt, cd_n;
    logic                   pending, pending_n;
    logic [CNT_W-1:0]       served_n;
    logic                   button_n, wait_n;

    // Stage p0: synchroniser chain for the asynchronous button
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_p0 <= '0;
        end else begin
            sync_p0 <= {sync_p0[SYNC_STAGES-2:0], btn_raw};
        end
    end

    assign btn_sync = sync_p0[SYNC_STAGES-1];

    // Stage p1: debounce -- the clean level follows only after
    // DEBOUNCE_CYCLES consecutive cycles of disagreement.
    // Stage p2: delayed clean level for rising-edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            db_cnt_p1    <= '0;
            btn_clean_p1 <= 1'b0;
            btn_clean_p2 <= 1'b0;
        end else begin
            btn_clean_p2 <= btn_clean_p1;
            if (btn_sync == btn_clean_p1) begin
                db_cnt_p1 <= '0;
            end else if (db_cnt_p1 == DB_LAST) begin
                btn_clean_p1 <= btn_sync;
                db_cnt_p1    <= '0;
            end else begin
                db_cnt_p1 <= db_cnt_p1 + 1'b1;
            end
        end
    end

    // Releases produce no event; only the 0->1 clean transition counts.
    assign press = btn_clean_p1 & ~btn_clean_p2;

    // Request FSM state and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            cd_cnt       <= '0;
            pending      <= 1'b0;
            served_count <= '0;
            button       <= 1'b0;
            wait_lamp    <= 1'b0;
        end else begin
            state        <= state_n;
            cd_cnt       <= cd_n;
            pending      <= pending_n;
            served_count <= served_n;
            button       <= button_n;
            wait_lamp    <= wait_n;
        end
    end

    always_comb begin
        state_n   = state;
        cd_n      = cd_cnt;
        pending_n = pending;
        served_n  = served_count;
        unique case (state)
            IDLE: begin
                if (press) state_n = REQUEST;
            end
            REQUEST: begin
                // Further presses are ignored here; nothing is queued.
                if (green_p) state_n = SERVING;
            end
            SERVING: begin
                if (!green_p) begin
                    state_n  = COOLDOWN;
                    cd_n     = CD_LOAD;
                    served_n = sat_inc(served_count);
                end
            end
            COOLDOWN: begin
                if (press) pending_n = 1'b1;
                // A press arriving on the last cooldown cycle is honoured
                // because pending_n already includes it.
                if (cd_cnt == '0) begin
                    state_n   = pending_n ? REQUEST : IDLE;
                    pending_n = 1'b0;
                end else begin
                    cd_n = cd_cnt - 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
        // Outputs are computed from the next state so they are registered
        // and change on the same edge as the state.
        button_n = (state_n == REQUEST);
        wait_n   = (state_n == REQUEST) || ((state_n == COOLDOWN) && pending_n);
    end

endmodule
